// File: rtl/param_clb_pkg.sv
// param_clb shared definitions: BLE slice layout, enable encodings, load FSM states.
// Used by param_clb and param_clb_ble (optional readback: PARAM_CLB_READBACK_EN).
package param_clb_pkg;

    localparam int BLE_CFG_W = 23;

    localparam int LUT_LSB  = 0;
    localparam int LUT_W    = 16;
    localparam int EN_LSB   = 16;
    localparam int EN_W     = 2;
    localparam int OMUX_BIT = 18;
    localparam int OSEL_LSB = 19;
    localparam int OSEL_W   = 4;

    typedef enum logic [1:0] {
        EN_LEFT  = 2'b00,
        EN_RIGHT = 2'b01,
        EN_ONE   = 2'b10,
        EN_UP    = 2'b11
    } en_ctrl_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        COMMIT = 2'b10
    } state_e;

endpackage

// File: rtl/param_clb_ble.sv
// One BLE: 4-input LUT, enable-gated FF, output select and per-side
// routing muxes (routing falls back to straight pass-through).
module param_clb_ble
    import param_clb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BLE_CFG_W-1:0] cfg,
    input  logic                 up_i,
    input  logic                 down_i,
    input  logic                 right_i,
    input  logic                 left_i,
    output logic                 up_o,
    output logic                 down_o,
    output logic                 right_o,
    output logic                 left_o
);

    logic [LUT_W-1:0]  lut;
    logic [OSEL_W-1:0] osel;
    logic              omux;
    en_ctrl_e          en_ctrl;
    logic [3:0]        addr;
    logic              lut_out;
    logic              en;
    logic              ff;
    logic              sig;

    assign lut     = cfg[LUT_LSB +: LUT_W];
    assign osel    = cfg[OSEL_LSB +: OSEL_W];
    assign omux    = cfg[OMUX_BIT];
    assign en_ctrl = en_ctrl_e'(cfg[EN_LSB +: EN_W]);

    // LUT bit 15 is addressed by addr 0 (MSB-first truth table)
    assign addr    = {up_i, down_i, right_i, left_i};
    assign lut_out = lut[4'd15 - addr];

    // Enable source select
    always_comb begin
        en = 1'b0;
        unique case (en_ctrl)
            EN_LEFT:  en = left_i;
            EN_RIGHT: en = right_i;
            EN_ONE:   en = 1'b1;
            EN_UP:    en = up_i;
        endcase
    end

    // Registered LUT output, loaded when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff <= 1'b0;
        end else if (en) begin
            ff <= lut_out;
        end
    end

    assign sig     = omux ? lut_out : ff;
    assign up_o    = osel[3] ? sig : down_i;
    assign down_o  = osel[2] ? sig : up_i;
    assign right_o = osel[1] ? sig : left_i;
    assign left_o  = osel[0] ? sig : right_i;

endmodule

// File: rtl/param_clb.sv
// Parameterised CLB: W BLEs plus a beat-serial frame loader with shadow/active
// configuration. Define PARAM_CLB_READBACK_EN to add the cfg_rdata readback port.
module param_clb
    import param_clb_pkg::*;
#(
    parameter int W     = 2,
    parameter int CFG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     up_i,
    input  logic [W-1:0]     down_i,
    input  logic [W-1:0]     right_i,
    input  logic [W-1:0]     left_i,
    output logic [W-1:0]     up_o,
    output logic [W-1:0]     down_o,
    output logic [W-1:0]     right_o,
    output logic [W-1:0]     left_o,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_data,
`ifdef PARAM_CLB_READBACK_EN
    output logic [CFG_W-1:0] cfg_rdata,
`endif
    output logic             cfg_ready,
    output logic             cfg_done
);

    localparam int FRAME_W = BLE_CFG_W * W;
    localparam int BEATS   = (FRAME_W + CFG_W - 1) / CFG_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    state_e             state;
    state_e             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] shadow_wr;
    logic [FRAME_W-1:0] active;
    logic               start_load;
    logic               beat;

    assign start_load = (state == IDLE) && cfg_start;
    assign beat       = (state == LOAD) && cfg_valid && !cfg_abort;

    // Next state and handshake outputs; abort beats a same-cycle beat
    always_comb begin
        state_n   = state;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) state_n = LOAD;
            end
            LOAD: begin
                cfg_ready = rst_n;
                if (cfg_abort) begin
                    state_n = IDLE;
                end else if (cfg_valid && cnt == LAST) begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                cfg_done = rst_n;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Load FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Beat counter: cleared on start, advanced per accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start_load) begin
            cnt <= '0;
        end else if (beat && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Merge the current beat into the frame; bits past FRAME_W drop out
    always_comb begin
        shadow_wr = shadow;
        for (int j = 0; j < CFG_W; j++) begin
            if (int'(cnt) * CFG_W + j < FRAME_W) begin
                shadow_wr[int'(cnt) * CFG_W + j] = cfg_data[j];
            end
        end
    end

    // Shadow frame: filled beat by beat during LOAD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (beat) begin
            shadow <= shadow_wr;
`ifdef PARAM_CLB_READBACK_EN
        end else if (start_load) begin
            shadow <= active;
`endif
        end
    end

`ifdef PARAM_CLB_READBACK_EN
    // Beat k of the snapshot, read before that beat overwrites it
    always_comb begin
        cfg_rdata = '0;
        for (int j = 0; j < CFG_W; j++) begin
            if (int'(cnt) * CFG_W + j < FRAME_W) begin
                cfg_rdata[j] = shadow[int'(cnt) * CFG_W + j];
            end
        end
    end
`endif

    // Active configuration: only ever updated from a complete frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= '0;
        end else if (state == COMMIT) begin
            active <= shadow;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_ble
        param_clb_ble u_ble (
            .clk     (clk),
            .rst_n   (rst_n),
            .cfg     (active[i*BLE_CFG_W +: BLE_CFG_W]),
            .up_i    (up_i[i]),
            .down_i  (down_i[i]),
            .right_i (right_i[i]),
            .left_i  (left_i[i]),
            .up_o    (up_o[i]),
            .down_o  (down_o[i]),
            .right_o (right_o[i]),
            .left_o  (left_o[i])
        );
    end

endmodule

// File: doc/param_clb.md
PARAM_CLB -- requirements
Module: param_clb

Interface
REQ-001 The block SHALL have parameter W, default 2: channel width per side, equal to the number of BLEs (LUT + FF slices).
REQ-002 The block SHALL have parameter CFG_W, default 8: configuration beat width in bits.
REQ-003 The block SHALL have the derived constants BLE_CFG_W = 23, FRAME_W = 23*W and BEATS = ceil(FRAME_W/CFG_W).
REQ-004 The block SHALL have input clk, 1 bit: the only clock.
REQ-005 The block SHALL have input rst_n, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have inputs up_i, down_i, right_i and left_i, each W bits: side inputs, with bit i feeding BLE i.
REQ-007 The block SHALL have outputs up_o, down_o, right_o and left_o, each W bits: side outputs.
REQ-008 The block SHALL have input cfg_start, 1 bit: begins a frame load.
REQ-009 The block SHALL have input cfg_abort, 1 bit: discards the frame load in progress.
REQ-010 The block SHALL have input cfg_valid, 1 bit, and input cfg_data, CFG_W bits: the configuration beat.
REQ-011 The block SHALL have outputs cfg_ready and cfg_done, each 1 bit: the beat handshake and the one-cycle commit pulse.

Function
REQ-012 The frame SHALL give BLE i bits [23i+22:23i], with fields 22:19 out_sel{up,down,right,left}, 18 omux (1 = LUT, 0 = FF), 17:16 en_ctrl and 15:0 lut.
REQ-013 BLE i SHALL form addr = {up_i[i],down_i[i],right_i[i],left_i[i]} and set lut_out = lut[15-addr], combinationally.
REQ-014 BLE i SHALL decode en_ctrl as 00 = left_i[i], 01 = right_i[i], 10 = constant 1, 11 = up_i[i]; the FF loads lut_out on the clk edge when the enable is 1.
REQ-015 BLE i SHALL set sig = omux ? lut_out : ff.
REQ-016 BLE i SHALL drive up_o[i] = out_sel[3] ? sig : down_i[i]; down_o[i] = [2] ? sig : up_i[i]; right_o[i] = [1] ? sig : left_i[i]; left_o[i] = [0] ? sig : right_i[i].
REQ-017 The load FSM SHALL have exactly the states IDLE, LOAD and COMMIT.
REQ-018 In IDLE, cfg_start=1 SHALL go to LOAD and clear the beat counter.
REQ-019 In LOAD, cfg_ready SHALL be 1; every other state SHALL hold cfg_ready at 0.
REQ-020 A beat SHALL be accepted when cfg_valid and cfg_ready are both 1, and the first beat SHALL fill frame bits [CFG_W-1:0], ascending.
REQ-021 Frame bits of the last beat that lie at or above FRAME_W SHALL be ignored.
REQ-022 Acceptance of beat BEATS-1 SHALL move the FSM to COMMIT.
REQ-023 In COMMIT, the shadow frame SHALL be copied to the active configuration on the clock edge, cfg_done SHALL be 1 for that cycle, and the next state SHALL be IDLE.
REQ-024 The new configuration SHALL first affect outputs in the cycle after COMMIT; FFs SHALL use the old configuration during COMMIT.
REQ-025 cfg_abort in LOAD SHALL win over a beat in the same cycle: go to IDLE, keep the active configuration, accept no beat.
REQ-026 cfg_start outside IDLE and cfg_abort outside LOAD SHALL be ignored.
REQ-027 cfg_valid while cfg_ready=0 SHALL be ignored and SHALL NOT be counted as a beat.
REQ-028 The datapath SHALL run continuously, including throughout any load.

Reset
REQ-029 rst_n=0 at a clk edge SHALL clear the active configuration to all-zero, giving pass-through routing with the FF selected.
REQ-030 rst_n=0 at a clk edge SHALL clear every FF, the shadow frame and the beat counter to 0, and return the FSM to IDLE.
REQ-031 During and after reset, cfg_ready and cfg_done SHALL be 0.
REQ-032 Reset during LOAD or COMMIT SHALL abandon the load, and no partial frame SHALL ever reach the active configuration.
REQ-033 After reset, up_o SHALL equal down_i and down_o SHALL equal up_i, combinationally.

Configuration
REQ-034 With PARAM_CLB_READBACK_EN defined, the block SHALL add output cfg_rdata, CFG_W bits.
REQ-035 With PARAM_CLB_READBACK_EN defined, entering LOAD SHALL snapshot the active frame, and while beat k is offered cfg_rdata SHALL present frame beat k of that snapshot, with zero padding above FRAME_W.
REQ-036 Without PARAM_CLB_READBACK_EN, the cfg_rdata port SHALL be absent and the shadow frame SHALL be write-only.

Structure
REQ-037 Package param_clb_pkg SHALL hold BLE_CFG_W, the field bit offsets, the en_ctrl enum (EN_LEFT, EN_RIGHT, EN_ONE, EN_UP) and the FSM state enum.
REQ-038 The block SHALL instantiate sub-module param_clb_ble once per bit (LUT, enable mux, FF, output muxes), driven by its 23-bit active slice.
REQ-039 The top level SHALL hold the FSM, the beat counter, the shadow frame, the active frame and the generate loop.

Verification
REQ-040 With W=2 and CFG_W=8 (BEATS=6): reset, then drive up_i=2'b10 and down_i=2'b01 -> up_o=2'b01, down_o=2'b10, and cfg_ready=0.
REQ-041 Load BLE0 = lut 16'h8000, omux=1, out_sel=4'b1000 -> after commit, up_o[0]=1 only when addr=4'b0000, otherwise 0.
REQ-042 Load a BLE0 frame with omux=0 and en_ctrl=EN_UP, then hold up_i[0]=0 while lut_out toggles -> sig holds its value, and it updates the cycle after up_i[0]=1.
REQ-043 Send cfg_abort after 3 of 6 beats -> cfg_done never rises, the outputs match the prior configuration, and the next load succeeds.
REQ-044 Deassert cfg_valid for 5 cycles mid-frame, then finish the frame -> cfg_done rises exactly once, in the cycle after the 6th accepted beat.
REQ-045 With READBACK_EN, load frame A then load frame B -> cfg_rdata during the B load returns the beats of A, including zero pad bits 47:46.
